// File: rtl/aes_round_sched.sv
// Iterative AES-128 round sequencer: applies AddRoundKey and drives a shared
// pipelined round datapath once per round, one job at a time.
module aes_round_sched #(
  parameter int unsigned NR         = 10,
  parameter int unsigned DP_LATENCY = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Data,
  output logic [127:0] o_Data,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [3:0]   o_Key_Idx,
  input  logic [127:0] i_Round_Key,
  output logic [127:0] o_Dp_Data,
  output logic         o_Dp_Valid,
  output logic         o_Dp_Last,
  input  logic [127:0] i_Dp_Data,
  input  logic         i_Dp_Valid,
  output logic         o_Err
);

  localparam int unsigned RND_W    = 4;
  localparam int unsigned WAIT_LIM = DP_LATENCY + TIMEOUT;
  localparam int unsigned CNT_W    = $clog2(WAIT_LIM + 1);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);
  localparam logic [CNT_W-1:0] CNT_EXP  = CNT_W'(WAIT_LIM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [127:0]       data_q,  data_d;
  logic               err_q,   err_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; cnt_q counts cycles since the current round was issued
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        err_d = i_Dp_Valid;
        if (i_Valid) begin
          data_d  = i_Data ^ i_Round_Key;
          round_d = RND_W'(1);
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        err_d   = i_Dp_Valid;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_Dp_Valid) begin
          data_d = i_Dp_Data ^ i_Round_Key;
          cnt_d  = '0;
          if (round_q == LAST_RND) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + RND_W'(1);
            state_d = S_ISSUE;
          end
        end else if (cnt_q == CNT_EXP) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        err_d = i_Dp_Valid;
        if (i_Ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  assign o_Ready    = (state_q == S_IDLE);
  assign o_Valid    = (state_q == S_DONE);
  assign o_Data     = data_q;
  assign o_Dp_Data  = data_q;
  assign o_Dp_Valid = (state_q == S_ISSUE);
  assign o_Dp_Last  = (state_q == S_ISSUE) && (round_q == LAST_RND);
  assign o_Key_Idx  = (state_q == S_IDLE) ? '0 : round_q;
  assign o_Err      = err_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: AES reference model, key store,
// fixed-latency datapath model and a ciphertext scoreboard.
module tb_aes_round_sched;

  localparam int unsigned NR    = 10;
  localparam int unsigned DPL   = 4;
  localparam int unsigned TMO   = 8;
  localparam int          CLK_P = 10;

  logic         clk;
  logic         rst_n;
  logic         i_Valid;
  logic         o_Ready;
  logic [127:0] i_Data;
  logic [127:0] o_Data;
  logic         o_Valid;
  logic         i_Ready;
  logic [3:0]   o_Key_Idx;
  logic [127:0] i_Round_Key;
  logic [127:0] o_Dp_Data;
  logic         o_Dp_Valid;
  logic         o_Dp_Last;
  logic [127:0] i_Dp_Data;
  logic         i_Dp_Valid;
  logic         o_Err;

  aes_round_sched #(.NR(NR), .DP_LATENCY(DPL), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_Valid     (i_Valid),
    .o_Ready     (o_Ready),
    .i_Data      (i_Data),
    .o_Data      (o_Data),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .o_Key_Idx   (o_Key_Idx),
    .i_Round_Key (i_Round_Key),
    .o_Dp_Data   (o_Dp_Data),
    .o_Dp_Valid  (o_Dp_Valid),
    .o_Dp_Last   (o_Dp_Last),
    .i_Dp_Data   (i_Dp_Data),
    .i_Dp_Valid  (i_Dp_Valid),
    .o_Err       (o_Err)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:15];
  logic [127:0] sb_q[$];
  logic         dp_v = 1'b0;
  logic [127:0] dp_d = '0;
  logic         spur = 1'b0;
  logic         flush = 1'b0;
  int           iss_cnt = 0;
  int           drop_at = 0;
  time          t_iss = 0;

  assign i_Round_Key = rk[o_Key_Idx];
  assign i_Dp_Valid  = dp_v | spur;
  assign i_Dp_Data   = dp_d;

  initial begin
    clk = 1'b0;
    forever #(CLK_P/2) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // One round as the datapath computes it: SubBytes, ShiftRows, MixColumns unless last
  function automatic logic [127:0] dp_round(input logic [127:0] s, input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) b[w+4*c] = a[w + 4*((c+w)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
        b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
        b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
        b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [127:0] st = pt ^ rk[0];
    for (int r = 1; r <= int'(NR); r++) st = dp_round(st, r == int'(NR)) ^ rk[r];
    return st;
  endfunction

  // Fixed-latency datapath model; also traces every issue
  initial begin
    logic         pv [DPL];
    logic [127:0] pd [DPL];
    for (int i = 0; i < int'(DPL); i++) begin pv[i] = 1'b0; pd[i] = '0; end
    forever begin
      @(negedge clk);
      dp_v = pv[0];
      dp_d = pd[0];
      for (int i = 0; i < int'(DPL) - 1; i++) begin pv[i] = pv[i+1]; pd[i] = pd[i+1]; end
      pv[DPL-1] = 1'b0;
      pd[DPL-1] = '0;
      if (flush) begin
        for (int i = 0; i < int'(DPL); i++) pv[i] = 1'b0;
        dp_v = 1'b0;
      end else if (o_Dp_Valid) begin
        iss_cnt++;
        t_iss = $time;
        chki("issue_key_idx", int'(o_Key_Idx), iss_cnt);
        chkb("issue_last", o_Dp_Last, iss_cnt == int'(NR));
        if (iss_cnt != drop_at) begin
          pv[DPL-1] = 1'b1;
          pd[DPL-1] = dp_round(o_Dp_Data, o_Dp_Last);
        end
      end
    end
  end

  task automatic launch(input logic [127:0] pt, input bit expect_done, output int waited);
    waited = 0;
    @(negedge clk);
    i_Data  = pt;
    i_Valid = 1'b1;
    while (!o_Ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chkb("launch_ready", o_Ready, 1'b1);
    chki("launch_key0", int'(o_Key_Idx), 0);
    if (expect_done) sb_q.push_back(ref_enc(pt));
    iss_cnt = 0;
    @(posedge clk);
    #1 i_Valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_Valid && n < 200);
    chkb("valid_seen", o_Valid, 1'b1);
  endtask

  task automatic check_out(input string tag);
    logic [127:0] exp = 'x;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    chk(tag, o_Data, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, o_Data, '0);
    chkb({tag, "_valid"}, o_Valid, 1'b0);
    chkb({tag, "_dpv"}, o_Dp_Valid, 1'b0);
    chkb({tag, "_dpl"}, o_Dp_Last, 1'b0);
    chkb({tag, "_err"}, o_Err, 1'b0);
    chki({tag, "_kidx"}, int'(o_Key_Idx), 0);
    chkb({tag, "_ready"}, o_Ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] pt_fips = 128'h3243f6a8885a308d313198a2e0370734;
    logic [127:0] ct_fips = 128'h3925841d02dc09fbdc118597196a0b32;
    logic [31:0]  w [0:43];
    logic [31:0]  t;
    logic [7:0]   rc, inv, y;
    int           n, waited;

    // S-box from GF(2^8) inverse plus affine map, then key expansion
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int v = 1; v < 256; v++) if (gmul(8'(x), 8'(v)) == 8'h01) inv = 8'(v);
      y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = y;
    end
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= int'(NR)) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;

    // Reset values
    rst_n = 1'b0; i_Valid = 1'b0; i_Ready = 1'b0; i_Data = '0;
    #(3*CLK_P + 2);
    chk_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;

    // FIPS-197 vector with backpressure on the result
    launch(pt_fips, 1'b1, waited);
    wait_valid(n);
    chki("fips_latency", n, 51);
    chk("fips_ct", o_Data, ct_fips);
    check_out("fips_sb");
    chki("fips_issues", iss_cnt, 10);
    i_Valid = 1'b1;
    i_Data  = 128'h00112233445566778899aabbccddeeff;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chkb("bp_valid", o_Valid, 1'b1);
      chkb("bp_ready", o_Ready, 1'b0);
      chk("bp_data", o_Data, ct_fips);
    end
    i_Ready = 1'b1;
    launch(128'h00112233445566778899aabbccddeeff, 1'b1, waited);
    chki("bp_accept_first_idle", waited, 0);
    wait_valid(n);
    chki("job2_latency", n, 51);
    check_out("job2_sb");
    chki("job2_issues", iss_cnt, 10);

    // Datapath drops the round-3 result
    drop_at = 3;
    launch(128'hdeadbeef0123456789abcdeffedcba98, 1'b0, waited);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_Err && n < 100);
    chkb("tmo_err", o_Err, 1'b1);
    chki("tmo_issues", iss_cnt, 3);
    chki("tmo_delay", int'(($time - t_iss) / CLK_P), 12);
    drop_at = 0;
    @(negedge clk);
    chkb("tmo_err_pulse", o_Err, 1'b0);
    chkb("tmo_ready", o_Ready, 1'b1);
    chkb("tmo_valid", o_Valid, 1'b0);

    // Spurious datapath strobe while idle
    @(negedge clk) spur = 1'b1;
    @(negedge clk) spur = 1'b0;
    chkb("spur_err", o_Err, 1'b1);
    chkb("spur_ready", o_Ready, 1'b1);
    @(negedge clk);
    chkb("spur_err_pulse", o_Err, 1'b0);
    launch(128'hffffffffffffffffffffffffffffffff, 1'b1, waited);
    wait_valid(n);
    chki("spur_job_latency", n, 51);
    check_out("spur_job_sb");

    // Reset during the round-5 wait, then a fresh job
    launch(128'h0f0e0d0c0b0a09080706050403020100, 1'b0, waited);
    n = 0;
    while (iss_cnt < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chki("rst_mid_round", iss_cnt, 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    flush = 1'b1;
    #1 chk_reset_vals("rstmid");
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rsthold");
    rst_n = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chkb("rst_no_err", o_Err, 1'b0);
    chkb("rst_ready", o_Ready, 1'b1);
    launch(pt_fips, 1'b1, waited);
    wait_valid(n);
    chki("post_rst_latency", n, 51);
    chk("post_rst_ct", o_Data, ct_fips);
    check_out("post_rst_sb");
    chki("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
